// File: rtl/mem_arbiter.sv
// Arbitrates one single-port backing memory between instruction fetch and data access.
// Data has priority; a starvation counter bounds how long fetch can be locked out.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 255,
    parameter logic [31:0] ERR_DATA     = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_ack,
    input  logic [31:0] m_rdata,
    output logic        bus_err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] IBUSY = 2'd1;
    localparam logic [1:0] DBUSY = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [31:0] STARVE_MAX = 32'(STARVE_LIMIT);
    localparam logic        FAIR_EN    = (STARVE_LIMIT != 0);
    localparam logic        TMO_EN     = (TIMEOUT != 0);
    localparam logic [31:0] TMO_LAST   = TMO_EN ? 32'(TIMEOUT) - 32'd1 : 32'd0;

    function automatic logic [31:0] starve_sat_inc(input logic [31:0] v);
        if (v >= STARVE_MAX)
            return STARVE_MAX;
        return v + 32'd1;
    endfunction

    logic [1:0]  state;
    logic [31:0] starve_cnt;
    logic [31:0] tmo_cnt;
    logic        fetch_starved;
    logic        d_win;
    logic        tmo_hit;

    assign fetch_starved = i_req && FAIR_EN && (starve_cnt == STARVE_MAX);
    assign d_win         = d_req && !fetch_starved;
    assign tmo_hit       = TMO_EN && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            tmo_cnt    <= '0;
            m_req      <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            i_ready    <= 1'b0;
            i_rdata    <= '0;
            d_ready    <= 1'b0;
            d_rdata    <= '0;
            bus_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_win) begin
                        state      <= DBUSY;
                        m_req      <= 1'b1;
                        m_we       <= d_we;
                        m_addr     <= d_addr;
                        m_wdata    <= d_wdata;
                        starve_cnt <= i_req ? starve_sat_inc(starve_cnt) : '0;
                    end else if (i_req) begin
                        state      <= IBUSY;
                        m_req      <= 1'b1;
                        m_we       <= 1'b0;
                        m_addr     <= i_addr;
                        m_wdata    <= '0;
                        starve_cnt <= '0;
                    end else begin
                        starve_cnt <= '0;
                    end
                end
                IBUSY, DBUSY: begin
                    // A real ack beats a timeout landing in the same cycle.
                    if (m_ack || tmo_hit) begin
                        state   <= RESP;
                        m_req   <= 1'b0;
                        tmo_cnt <= '0;
                        if (!m_ack)
                            bus_err <= 1'b1;
                        if (state == IBUSY) begin
                            i_ready <= 1'b1;
                            i_rdata <= m_ack ? m_rdata : ERR_DATA;
                        end else begin
                            d_ready <= 1'b1;
                            if (!m_we)
                                d_rdata <= m_ack ? m_rdata : ERR_DATA;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                RESP: begin
                    // No grant here: the requester uses this edge to retire its request.
                    i_ready <= 1'b0;
                    d_ready <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: memory responder, ready-pulse scoreboard, grant-order log.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ack;
    logic [31:0] m_rdata;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    int  ack_lat    = 0;
    bit  ack_en     = 1'b1;
    bit  manual_ack = 1'b0;

    logic [31:0] exp_i[$];
    logic [31:0] exp_d[$];
    logic [31:0] grant_log[$];
    logic [31:0] d_model = 32'h0;

    mem_arbiter #(.STARVE_LIMIT(2), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata), .bus_err(bus_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h100)
            return 32'h2402000A;
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory responder: acks ack_lat cycles after m_req rises, logs each grant address.
    initial begin
        int  wait_cnt;
        bit  prev_req;
        wait_cnt = 0;
        prev_req = 1'b0;
        m_ack    = 1'b0;
        m_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            m_ack = 1'b0;
            if (m_req && !prev_req)
                grant_log.push_back(m_addr);
            prev_req = m_req;
            if (manual_ack) begin
                m_ack   = 1'b1;
                m_rdata = 32'h12345678;
            end else if (m_req && ack_en) begin
                if (wait_cnt >= ack_lat) begin
                    m_ack    = 1'b1;
                    m_rdata  = m_we ? 32'h0BAD0BAD : mem_val(m_addr);
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Ready-pulse scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (i_ready) begin
                if (exp_i.size() == 0) check("i_unexpected_ready", 32'd1, 32'd0);
                else check("i_rdata", i_rdata, exp_i.pop_front());
            end
            if (d_ready) begin
                if (exp_d.size() == 0) check("d_unexpected_ready", 32'd1, 32'd0);
                else check("d_rdata", d_rdata, exp_d.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready(input bit is_d, input string tag);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (is_d ? d_ready : i_ready) seen = 1'b1;
        end
        check({tag, "_ready_seen"}, 32'(seen), 32'd1);
        @(posedge clk); #1;
        check({tag, "_single_pulse"}, 32'(is_d ? d_ready : i_ready), 32'd0);
    endtask

    task automatic do_fetch(input logic [31:0] a, input string tag);
        i_addr = a;
        i_req  = 1'b1;
        exp_i.push_back(mem_val(a));
        wait_ready(1'b0, tag);
        i_req = 1'b0;
    endtask

    task automatic do_data(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input string tag);
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        d_req   = 1'b1;
        if (!we) d_model = mem_val(a);
        exp_d.push_back(d_model);
        wait_ready(1'b1, tag);
        d_req = 1'b0;
        d_we  = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_m_req"},   32'(m_req),   32'd0);
        check({tag, "_m_we"},    32'(m_we),    32'd0);
        check({tag, "_m_addr"},  m_addr,       32'd0);
        check({tag, "_m_wdata"}, m_wdata,      32'd0);
        check({tag, "_i_ready"}, 32'(i_ready), 32'd0);
        check({tag, "_i_rdata"}, i_rdata,      32'd0);
        check({tag, "_d_ready"}, 32'(d_ready), 32'd0);
        check({tag, "_d_rdata"}, d_rdata,      32'd0);
        check({tag, "_bus_err"}, 32'(bus_err), 32'd0);
    endtask

    initial begin
        int n;
        logic [31:0] exp_order[6];
        reset = 1'b1; i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // Isolated fetch, 2-cycle ack latency
        ack_lat = 2;
        i_addr = 32'h100; i_req = 1'b1;
        exp_i.push_back(32'h2402000A);
        @(posedge clk); #1;
        check("fetch_m_req", 32'(m_req), 32'd1);
        check("fetch_m_addr", m_addr, 32'h100);
        check("fetch_m_we", 32'(m_we), 32'd0);
        wait_ready(1'b0, "fetch");
        i_req = 1'b0;
        check("fetch_bus_err", 32'(bus_err), 32'd0);
        @(posedge clk); #1;

        // Simultaneous load and fetch, 1-cycle ack latency
        ack_lat = 1;
        d_we = 1'b0; d_addr = 32'h2000; d_req = 1'b1;
        d_model = mem_val(32'h2000);
        exp_d.push_back(d_model);
        i_addr = 32'h104; i_req = 1'b1;
        exp_i.push_back(mem_val(32'h104));
        @(posedge clk); #1;
        check("sim_first_grant_addr", m_addr, 32'h2000);
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            n++;
            if (m_ack) break;
        end
        check("sim_data_ack_seen", 32'(m_ack), 32'd1);
        #1;
        check("sim_d_ready_first", 32'(d_ready), 32'd1);
        check("sim_i_ready_waits", 32'(i_ready), 32'd0);
        check("sim_m_req_dropped", 32'(m_req), 32'd0);
        @(posedge clk); #1;
        d_req = 1'b0;
        check("sim_turnaround_gap", 32'(m_req), 32'd0);
        @(posedge clk); #1;
        check("sim_fetch_m_req", 32'(m_req), 32'd1);
        check("sim_fetch_m_addr", m_addr, 32'h104);
        wait_ready(1'b0, "sim_fetch");
        i_req = 1'b0;
        @(posedge clk); #1;

        // Store leaves d_rdata untouched
        d_we = 1'b1; d_addr = 32'h2004; d_wdata = 32'hCAFEF00D; d_req = 1'b1;
        exp_d.push_back(d_model);
        @(posedge clk); #1;
        check("store_m_req", 32'(m_req), 32'd1);
        check("store_m_we", 32'(m_we), 32'd1);
        check("store_m_addr", m_addr, 32'h2004);
        check("store_m_wdata", m_wdata, 32'hCAFEF00D);
        wait_ready(1'b1, "store");
        d_req = 1'b0; d_we = 1'b0;
        check("store_d_rdata_kept", d_rdata, d_model);
        @(posedge clk); #1;

        // Starvation with STARVE_LIMIT=2: expect D, D, I, D, D, I
        ack_lat = 0;
        grant_log.delete();
        fork
            begin
                do_data(1'b0, 32'h3000, 32'h0, "starve_d0");
                do_data(1'b0, 32'h3004, 32'h0, "starve_d1");
                do_data(1'b0, 32'h3008, 32'h0, "starve_d2");
                do_data(1'b0, 32'h300C, 32'h0, "starve_d3");
            end
            begin
                do_fetch(32'h200, "starve_i0");
                do_fetch(32'h204, "starve_i1");
            end
        join
        exp_order[0] = 32'h3000; exp_order[1] = 32'h3004; exp_order[2] = 32'h200;
        exp_order[3] = 32'h3008; exp_order[4] = 32'h300C; exp_order[5] = 32'h204;
        check("starve_grant_count", 32'(grant_log.size()), 32'd6);
        for (int k = 0; k < 6; k++) begin
            if (k < grant_log.size()) check($sformatf("starve_grant%0d", k), grant_log[k], exp_order[k]);
        end
        @(posedge clk); #1;

        // Timeout with TIMEOUT=8, memory never acks
        ack_en = 1'b0;
        i_addr = 32'h400; i_req = 1'b1;
        exp_i.push_back(32'hDEADBEEF);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (m_req) n++;
            if (i_ready) break;
        end
        check("tmo_busy_cycles", 32'(n), 32'd8);
        check("tmo_i_ready", 32'(i_ready), 32'd1);
        check("tmo_m_req_low", 32'(m_req), 32'd0);
        @(posedge clk); #1;
        i_req = 1'b0;
        check("tmo_single_pulse", 32'(i_ready), 32'd0);
        check("tmo_bus_err", 32'(bus_err), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("tmo_bus_err_sticky", 32'(bus_err), 32'd1);

        // Reset during DBUSY, then a late ack
        d_we = 1'b0; d_addr = 32'h5000; d_req = 1'b1;
        @(posedge clk); #1;
        check("rst_busy_m_req", 32'(m_req), 32'd1);
        check("rst_busy_m_addr", m_addr, 32'h5000);
        @(posedge clk); #1;
        reset = 1'b1; d_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        check_all_zero("rst_mid");
        manual_ack = 1'b1;
        @(posedge clk); #1;
        manual_ack = 1'b0;
        check("rst_late_ack_m_req", 32'(m_req), 32'd0);
        check("rst_late_ack_d_ready", 32'(d_ready), 32'd0);
        @(posedge clk); #1;
        check("rst_no_d_ready", 32'(d_ready), 32'd0);
        ack_en = 1'b1; ack_lat = 1;
        do_data(1'b0, 32'h6000, 32'h0, "post_rst_load");
        check("post_rst_bus_err", 32'(bus_err), 32'd0);
        repeat (2) @(posedge clk);
        #1;

        check("exp_i_drained", 32'(exp_i.size()), 32'd0);
        check("exp_d_drained", 32'(exp_d.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
